// File: rtl/frame_acc_relu.sv
// frame_acc_relu: accumulates signed partial sums over a frame, adds a
// per-frame bias on the first beat, then applies an arithmetic right shift
// and a saturating ReLU before presenting one output word per frame.
// Output words are grouped in runs of NUM_FRAMES; last_o tags the final
// word of each group.
module frame_acc_relu #(
    parameter int I_BW       = 32,
    parameter int ACC_BW     = 40,
    parameter int BIAS_BW    = 16,
    parameter int O_BW       = 8,
    parameter int SHIFT      = 4,
    parameter int NUM_FRAMES = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [I_BW-1:0]    data_i,
    input  logic               valid_i,
    input  logic               last_i,
    output logic               ready_o,
    input  logic [BIAS_BW-1:0] bias_i,
    output logic [O_BW-1:0]    data_o,
    output logic               valid_o,
    output logic               last_o,
    input  logic               ready_i
);

    // Group counter width; a one-frame group still needs a 1-bit counter.
    localparam int GRP_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_FRAMES - 1);

    // Largest positive output value, in accumulator width for the clamp
    // comparison and in output width for the saturated result.
    localparam logic signed [ACC_BW-1:0] O_MAX_ACC = ACC_BW'((2 ** (O_BW - 1)) - 1);
    localparam logic [O_BW-1:0]          O_MAX     = O_BW'((2 ** (O_BW - 1)) - 1);

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [ACC_BW-1:0] acc_q, acc_d;
    logic                     first_q, first_d;
    logic [GRP_W-1:0]         grp_q, grp_d;
    logic [O_BW-1:0]          data_q, data_d;
    logic                     last_q, last_d;

    logic                     beat_acc;
    logic                     out_hs;
    logic signed [ACC_BW-1:0] data_ext;
    logic signed [ACC_BW-1:0] bias_ext;
    logic signed [ACC_BW-1:0] acc_sum;
    logic signed [ACC_BW-1:0] shifted;
    logic [O_BW-1:0]          act;

    // Handshake decode: ready only while accumulating, valid only while
    // presenting a result, so the two handshakes are mutually exclusive.
    assign ready_o  = (state_q == ST_ACCUM);
    assign valid_o  = (state_q == ST_OUTPUT);
    assign beat_acc = valid_i && ready_o;
    assign out_hs   = valid_o && ready_i;
    assign data_o   = data_q;
    assign last_o   = last_q;

    // Datapath arithmetic: sign-extended add, arithmetic shift, ReLU clamp.
    always_comb begin
        data_ext = ACC_BW'($signed(data_i));
        bias_ext = ACC_BW'($signed(bias_i));
        // The bias seeds the sum on the first beat instead of the old acc.
        acc_sum  = (first_q ? bias_ext : acc_q) + data_ext;
        shifted  = acc_sum >>> SHIFT;
        if (shifted < 0) begin
            act = '0;
        end else if (shifted > O_MAX_ACC) begin
            act = O_MAX;
        end else begin
            act = shifted[O_BW-1:0];
        end
    end

    // FSM next-state: ACCUM until a last beat is taken, OUTPUT until drained.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM: begin
                if (beat_acc && last_i) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_hs) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Datapath next-state: accumulate beats, capture result, count groups.
    always_comb begin
        acc_d   = acc_q;
        first_d = first_q;
        grp_d   = grp_q;
        data_d  = data_q;
        last_d  = last_q;
        if (beat_acc) begin
            acc_d   = acc_sum;
            // A last beat re-arms the bias for the next frame.
            first_d = last_i;
            if (last_i) begin
                data_d = act;
                last_d = (grp_q == GRP_LAST);
            end
        end
        if (out_hs) begin
            // Keep last_o low whenever no word is being presented.
            last_d = 1'b0;
            grp_d  = (grp_q == GRP_LAST) ? '0 : grp_q + GRP_W'(1);
        end
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values; reset is sampled on the edge.
        if (!rst_n_i) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset drops any partial frame and pending word.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            grp_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            first_q <= first_d;
            grp_q   <= grp_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_frame_acc_relu.sv
// Self-checking bench for frame_acc_relu: directed scenarios plus random
// frames, with a queue-based scoreboard fed by a frame-level reference model
// and drained by an independent output monitor.
module tb_frame_acc_relu;

    localparam int I_BW       = 32;
    localparam int ACC_BW     = 40;
    localparam int BIAS_BW    = 16;
    localparam int O_BW       = 8;
    localparam int SHIFT      = 4;
    localparam int NUM_FRAMES = 3;

    logic               clk = 1'b0;
    logic               rst_n_i = 1'b0;
    logic [I_BW-1:0]    data_i = '0;
    logic               valid_i = 1'b0;
    logic               last_i = 1'b0;
    logic               ready_o;
    logic [BIAS_BW-1:0] bias_i = '0;
    logic [O_BW-1:0]    data_o;
    logic               valid_o;
    logic               last_o;
    logic               ready_i = 1'b1;

    always #5 clk = ~clk;

    frame_acc_relu #(
        .I_BW(I_BW), .ACC_BW(ACC_BW), .BIAS_BW(BIAS_BW),
        .O_BW(O_BW), .SHIFT(SHIFT), .NUM_FRAMES(NUM_FRAMES)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .last_i (last_i),
        .ready_o(ready_o),
        .bias_i (bias_i),
        .data_o (data_o),
        .valid_o(valid_o),
        .last_o (last_o),
        .ready_i(ready_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        logic [O_BW-1:0] data;
        logic            last;
    } exp_t;

    exp_t   exp_q[$];
    longint m_sum   = 0;
    bit     m_first = 1'b1;
    int     m_grp   = 0;

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - ACC_BW)) >>> (64 - ACC_BW);
    endfunction

    function automatic logic [O_BW-1:0] relu_sat(input longint a);
        longint r;
        longint max_v;
        r     = a >>> SHIFT;
        max_v = (longint'(1) <<< (O_BW - 1)) - 1;
        if (r < 0) return '0;
        if (r > max_v) r = max_v;
        return r[O_BW-1:0];
    endfunction

    task automatic model_beat(input longint d, input longint b, input bit last);
        exp_t e;
        if (m_first) m_sum = wrap_acc(b + d);
        else         m_sum = wrap_acc(m_sum + d);
        m_first = last;
        if (last) begin
            e.data = relu_sat(m_sum);
            e.last = (m_grp == NUM_FRAMES - 1);
            exp_q.push_back(e);
            m_grp = (m_grp + 1) % NUM_FRAMES;
        end
    endtask

    // ---------------- downstream ready control ----------------
    // 0: always ready, 1: random, 2: stalled
    int rdy_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b0;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n_i) begin
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output valid_o", valid_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_o", data_o, e.data);
                        check("last_o", last_o, e.last);
                    end
                end else if (!valid_o) begin
                    check("last_o_idle", last_o, 0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input longint d, input longint b, input bit last, output int waits);
        bit taken;
        data_i  = I_BW'(d);
        bias_i  = BIAS_BW'(b);
        last_i  = last;
        valid_i = 1'b1;
        waits   = 0;
        taken   = 1'b0;
        while (!taken) begin
            @(negedge clk);
            if (ready_o) taken = 1'b1;
            else         waits++;
            @(posedge clk);
            #1;
            if (!taken && waits > 200) begin
                check("accept_timeout ready_o", ready_o, 1);
                valid_i = 1'b0;
                last_i  = 1'b0;
                return;
            end
        end
        model_beat(d, b, last);
        valid_i = 1'b0;
        last_i  = 1'b0;
        if (last) begin
            @(negedge clk);
            check("valid_latency", valid_o, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        exp_q.delete();
        m_first = 1'b1;
        m_sum   = 0;
        m_grp   = 0;
        @(negedge clk);
        check("rst_ready_o", ready_o, 1);
        check("rst_valid_o", valid_o, 0);
        check("rst_last_o", last_o, 0);
        check("rst_data_o", data_o, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int     w;
        int     nbeats;
        longint d;
        longint b;
        logic [15:0] rb;

        do_reset();

        // Three-beat frame, bias 0: 96 >>> 4 = 6.
        send_beat(16, 0, 1'b0, w);
        send_beat(32, 0, 1'b0, w);
        send_beat(48, 0, 1'b1, w);

        // Negative clamps to 0, large value saturates to 127.
        send_beat(-100, 20, 1'b1, w);
        send_beat(4000, 0, 1'b1, w);

        // Downstream stall: output held, upstream beat not consumed.
        rdy_mode = 2;
        idle(1);
        send_beat(64, 0, 1'b1, w);
        data_i  = I_BW'(999);
        bias_i  = '0;
        last_i  = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid_o", valid_o, 1);
            check("stall_ready_o", ready_o, 0);
            if (exp_q.size() > 0) check("stall_data_o", data_o, exp_q[0].data);
        end
        rdy_mode = 0;
        send_beat(999, 0, 1'b1, w);
        check("ready_after_handshake_waits", w, 1);

        // Four one-beat frames of 32: group counter wraps.
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(32, 0, 1'b1, w);

        // Reset mid-frame discards partial sum.
        send_beat(800, 0, 1'b0, w);
        send_beat(800, 0, 1'b0, w);
        do_reset();
        send_beat(16, 0, 1'b1, w);

        // Bias only taken from the first beat.
        send_beat(0, 64, 1'b0, w);
        send_beat(0, 1000, 1'b1, w);

        // Randomized frames with random downstream backpressure.
        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            nbeats = $urandom_range(1, 5);
            for (int k = 0; k < nbeats; k++) begin
                if ($urandom_range(0, 7) == 0) d = longint'($signed($urandom));
                else                           d = longint'($urandom_range(0, 1000)) - 300;
                if ($urandom_range(0, 5) == 0) begin
                    rb = 16'($urandom);
                    b  = longint'($signed(rb));
                end else begin
                    b = longint'($urandom_range(0, 400)) - 200;
                end
                send_beat(d, b, (k == nbeats - 1), w);
                idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 14) == 0) do_reset();
        end

        // Drain any outstanding words.
        rdy_mode = 0;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
